rpn_entry_sequencer: RTL
========================

# rpn_entry_sequencer

Operand/opcode entry controller for the RPN calculator. Sequences operand A, operand B and the opcode from the switch bus into registers feeding the ALU datapath. Captures the ALU result and flags, and selects the value shown on the 7-segment driver. Sits between the button debouncers and the ALU/display blocks inside the calculator top.

## Interface

Parameters:
- N, 16, data width of operands, result and display value
- OPCODE_W, 5, opcode width; the opcode is taken from DataIn[OPCODE_W-1:0]

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Enter  in  1  debounced level of the Enter button
- Undo  in  1  debounced level of the Undo button
- DataIn  in  N  switch value
- AluResult  in  N  combinational ALU result of OpA/OpB/OpCode
- AluFlags  in  4  combinational ALU flags
- OpA  out  N  operand A register
- OpB  out  N  operand B register
- OpCode  out  OPCODE_W  opcode register
- DisplayValue  out  N  value for the 7-segment driver
- Flags  out  4  latched ALU flags
- Status  out  3  current state encoding

## Operation

- Edge detection:
  - Registers enter_q and undo_q hold the previous samples.
  - press = Enter & ~enter_q; undo_press = Undo & ~undo_q.
  - Both registers reset to 1, so a button held through reset never produces a press.
- States and Status encoding: WAIT_OPA=0, WAIT_OPB=1, WAIT_OPCODE=2, EXEC=3, SHOW_RESULT=4. Encodings 5–7 are unreachable; if entered, the next state is WAIT_OPA.
- Transitions on press:
  - WAIT_OPA: OpA<=DataIn, go to WAIT_OPB.
  - WAIT_OPB: OpB<=DataIn, go to WAIT_OPCODE.
  - WAIT_OPCODE: OpCode<=DataIn[OPCODE_W-1:0], go to EXEC.
  - SHOW_RESULT: behaviour set by Configuration.
- EXEC lasts exactly one cycle, then goes unconditionally to SHOW_RESULT. On that transition: Result register<=AluResult, Flags<=AluFlags.
- Transitions on undo_press:
  - WAIT_OPA: OpA<=0, stay.
  - WAIT_OPB: OpA<=0, go to WAIT_OPA.
  - WAIT_OPCODE: OpB<=0, go to WAIT_OPB.
  - SHOW_RESULT: Flags<=0, go to WAIT_OPCODE. OpA, OpB and OpCode are retained.
- Simultaneous press and undo_press: undo_press wins and press is discarded.
- Any press or undo_press during EXEC is discarded.
- DisplayValue (combinational from state):
  - WAIT_OPA, WAIT_OPB: DataIn.
  - WAIT_OPCODE: zero-extended DataIn[OPCODE_W-1:0].
  - EXEC: OpB.
  - SHOW_RESULT: Result register.
- Flags are nonzero only in SHOW_RESULT, or after chaining (see Configuration). They are cleared on entry to WAIT_OPA.

## Timing

- Reset values: Status=0 (WAIT_OPA); OpA=0, OpB=0, OpCode=0, Result=0, Flags=0; DisplayValue=DataIn.
- Reset mid-operation (any state) returns to WAIT_OPA with all registers cleared on the same edge.
- Press latency:
  - The state changes on the first clk edge at which Enter is sampled 1 after being sampled 0.
  - Operand/opcode registers update on that same edge.
- From the press edge in WAIT_OPCODE: EXEC is entered on that edge, and SHOW_RESULT with a valid Result/Flags on the next edge (2 edges total).
- A held button produces exactly one press. Releasing and re-pressing produces another.
- The ALU must settle within one clk period. OpA, OpB and OpCode stay constant throughout EXEC.

## Configuration

- Macro: RPN_CHAIN_EN
- Defined:
  - press in SHOW_RESULT performs OpA<=Result, OpB<=0, OpCode<=0 and goes to WAIT_OPB.
  - Flags are retained until the next EXEC.
  - Undo in that WAIT_OPB still clears OpA and goes to WAIT_OPA.
- Not defined:
  - press in SHOW_RESULT clears OpA, OpB, OpCode, Result and Flags and goes to WAIT_OPA.

## Test plan

Bench ALU model: opcode 0 = add, opcode 1 = sub; flags = {N, Z, C, V}.

- Full sequence: reset, DataIn=0x0005 press, 0x0003 press, 0x0000 press -> Status 0→1→2→3→4; two edges after the last press DisplayValue=0x0008, Flags=0.
- Undo walk-back: after OpA=0x1234, OpB=0x0010, undo, undo -> Status 2→1→0; OpB=0, OpA=0; DisplayValue follows DataIn.
- Simultaneous Enter and Undo rising in WAIT_OPCODE -> Status=1, OpB=0, OpCode unchanged.
- Held button: Enter held high for 50 cycles in WAIT_OPA -> a single transition to WAIT_OPB. Enter high during reset release -> Status stays 0.
- Sub with result zero (0x0007, 0x0007, op 1) -> DisplayValue=0x0000, Flags Z bit set. Then press:
  - with RPN_CHAIN_EN: Status=1, OpA=0x0000, Flags kept.
  - without RPN_CHAIN_EN: Status=0, all registers 0.
- Reset asserted for one cycle while in SHOW_RESULT -> the next edge gives Status=0, Flags=0, Result=0.

Source files
------------

// File: rtl/rpn_entry_sequencer_if.sv
// Bus bundle between the RPN entry sequencer and its surroundings (buttons, switches, ALU, display).
// The sequencer connects through the slave modport; the driving environment uses master.
interface rpn_entry_sequencer_if #(
  parameter int unsigned N        = 16,
  parameter int unsigned OPCODE_W = 5
);
  logic                Enter;
  logic                Undo;
  logic [N-1:0]        DataIn;
  logic [N-1:0]        AluResult;
  logic [3:0]          AluFlags;
  logic [N-1:0]        OpA;
  logic [N-1:0]        OpB;
  logic [OPCODE_W-1:0] OpCode;
  logic [N-1:0]        DisplayValue;
  logic [3:0]          Flags;
  logic [2:0]          Status;

  modport master (
    output Enter, Undo, DataIn, AluResult, AluFlags,
    input  OpA, OpB, OpCode, DisplayValue, Flags, Status
  );

  modport slave (
    input  Enter, Undo, DataIn, AluResult, AluFlags,
    output OpA, OpB, OpCode, DisplayValue, Flags, Status
  );
endinterface

// File: rtl/rpn_entry_sequencer.sv
// Operand/opcode entry sequencer for the RPN calculator: captures A, B, opcode, then ALU result.
// Define RPN_CHAIN_EN to make Enter in SHOW_RESULT chain the result into operand A.
module rpn_entry_sequencer #(
  parameter int unsigned N        = 16,
  parameter int unsigned OPCODE_W = 5
) (
  input logic                  clk,
  input logic                  reset,
  rpn_entry_sequencer_if.slave bus
);

  localparam logic [2:0] StWaitOpa    = 3'd0;
  localparam logic [2:0] StWaitOpb    = 3'd1;
  localparam logic [2:0] StWaitOpcode = 3'd2;
  localparam logic [2:0] StExec       = 3'd3;
  localparam logic [2:0] StShowResult = 3'd4;

  logic [2:0]          state_q, state_d;
  logic                enter_q, undo_q;
  logic [N-1:0]        opa_q, opa_d;
  logic [N-1:0]        opb_q, opb_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [N-1:0]        result_q, result_d;
  logic [3:0]          flags_q, flags_d;
  logic                press, undo_press;

  assign press      = bus.Enter & ~enter_q;
  assign undo_press = bus.Undo & ~undo_q;

  // Undo is tested before press everywhere, so it wins when both rise together.
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opcode_d = opcode_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      StWaitOpa: begin
        if (undo_press) begin
          opa_d   = '0;
          flags_d = '0;
        end else if (press) begin
          opa_d   = bus.DataIn;
          state_d = StWaitOpb;
        end
      end
      StWaitOpb: begin
        if (undo_press) begin
          opa_d   = '0;
          flags_d = '0;
          state_d = StWaitOpa;
        end else if (press) begin
          opb_d   = bus.DataIn;
          state_d = StWaitOpcode;
        end
      end
      StWaitOpcode: begin
        if (undo_press) begin
          opb_d   = '0;
          state_d = StWaitOpb;
        end else if (press) begin
          opcode_d = bus.DataIn[OPCODE_W-1:0];
          state_d  = StExec;
        end
      end
      StExec: begin
        // Buttons are ignored here; the ALU has had one full cycle on stable operands.
        result_d = bus.AluResult;
        flags_d  = bus.AluFlags;
        state_d  = StShowResult;
      end
      StShowResult: begin
        if (undo_press) begin
          flags_d = '0;
          state_d = StWaitOpcode;
        end else if (press) begin
`ifdef RPN_CHAIN_EN
          opa_d    = result_q;
          opb_d    = '0;
          opcode_d = '0;
          state_d  = StWaitOpb;
`else
          opa_d    = '0;
          opb_d    = '0;
          opcode_d = '0;
          result_d = '0;
          flags_d  = '0;
          state_d  = StWaitOpa;
`endif
        end
      end
      default: begin
        flags_d = '0;
        state_d = StWaitOpa;
      end
    endcase
  end

  // Edge detectors reset high so a button held through reset never counts as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StWaitOpa;
      enter_q  <= 1'b1;
      undo_q   <= 1'b1;
      opa_q    <= '0;
      opb_q    <= '0;
      opcode_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      enter_q  <= bus.Enter;
      undo_q   <= bus.Undo;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  logic [N-1:0] display;

  always_comb begin
    display = bus.DataIn;
    case (state_q)
      StWaitOpa, StWaitOpb: display = bus.DataIn;
      StWaitOpcode:         display = {{(N-OPCODE_W){1'b0}}, bus.DataIn[OPCODE_W-1:0]};
      StExec:               display = opb_q;
      StShowResult:         display = result_q;
      default:              display = bus.DataIn;
    endcase
  end

  assign bus.OpA          = opa_q;
  assign bus.OpB          = opb_q;
  assign bus.OpCode       = opcode_q;
  assign bus.DisplayValue = display;
  assign bus.Flags        = flags_q;
  assign bus.Status       = state_q;

endmodule
